serial_add_ctrl: RTL and testbench

Sequencer that performs a WIDTH-bit addition using one external 1-bit full adder (x, y, Cin -> Sum, Cout), processing one bit per clock, LSB first. It latches operands on a start pulse and drives the full adder's inputs from internal shift registers. It feeds each carry-out back as the next carry-in, collects the sum bits and reports completion with a one-cycle done pulse. It sits between a requesting unit and the shared 1-bit adder cell.

---
 rtl/serial_add_ctrl.sv | 155 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial WIDTH-bit adder sequencer driving one shared external 1-bit full adder, LSB first.
// Latency : start accepted at edge 0 -> busy for WIDTH cycles, done pulse in cycle WIDTH, idle again after edge WIDTH+1.
// Backpr. : none; start is sampled only in IDLE, and any start seen in RUN/DONE is dropped, not queued.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, a, b, cin      request and operands, captured when start is accepted in IDLE
//   fa_x, fa_y, fa_cin    drive the external full adder (0 when not in RUN)
//   fa_sum, fa_cout       results returned by the external full adder
//   busy, done            RUN indicator and one-cycle completion pulse
//   sum, cout             registered result, updated only when an addition completes

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Control signals decoded in the combinational FSM process.
    logic             accept;     // start taken in IDLE this cycle
    logic             step;       // one bit processed this cycle
    logic             last_step;  // final bit processed this cycle

    // The sum bit arriving this cycle lands in the MSB; after WIDTH steps
    // the first (LSB) bit has shifted all the way down to bit 0.
    logic [WIDTH-1:0] s_next;
    assign s_next = {fa_sum, s_sh[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fa_x      = 1'b0;
        fa_y      = 1'b0;
        fa_cin    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                step   = 1'b1;
                // Adder inputs come straight from registers so the external
                // cell sees a stable operand bit for the whole cycle.
                fa_x   = a_sh[0];
                fa_y   = b_sh[0];
                fa_cin = carry;
                if (cnt == LAST_BIT) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand / partial-sum shift registers and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            s_sh  <= s_next;
            carry <= fa_cout;
            // Exit happens at WIDTH-1, so the counter never needs to wrap.
            cnt   <= cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result registers: only written on the RUN->DONE edge so the
    // requester never observes a partially assembled sum.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_step) begin
            sum  <= s_next;
            cout <= fa_cout;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Purpose : self-checking bench for serial_add_ctrl with a behavioural full adder on the fa_* ports.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpr. : n/a; directed scenarios followed by randomized operands checked against plain arithmetic.

module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         fa_x;
    logic         fa_y;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors;
    int checks;

    // Result the DUT must currently be holding on sum/cout.
    logic [W-1:0] hold_sum;
    logic         hold_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .fa_x    (fa_x),
        .fa_y    (fa_y),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    // Behavioural 1-bit full adder.
    assign {fa_cout, fa_sum} = 2'(fa_x) + 2'(fa_y) + 2'(fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".fa"}, 32'({fa_x, fa_y, fa_cin}), 32'd0);
        chk({tag, ".sum"}, 32'(sum), 32'(hold_sum));
        chk({tag, ".cout"}, 32'(cout), 32'(hold_cout));
    endtask

    // Runs one addition starting from IDLE (called just after an edge).
    // poke_at >= 0 : raise start with a=b=0xFF so it is sampled at that edge.
    // rst_at  >= 0 : assert rst so it is sampled at that edge (aborts).
    task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input logic c_v, input int poke_at, input int rst_at);
        int total;
        int lo;
        int mod;
        total = int'(a_v) + int'(b_v) + int'(c_v);
        start = 1'b1;
        a     = a_v;
        b     = b_v;
        cin   = c_v;
        tick();  // edge 0: accepted
        for (int k = 0; k < W; k++) begin
            start = 1'b0;
            // Operand changes after acceptance must not matter.
            a     = 8'($urandom);
            b     = 8'($urandom);
            cin   = 1'($urandom);
            mod   = 1 << k;
            lo    = (int'(a_v) % mod) + (int'(b_v) % mod) + int'(c_v);
            chk("run.busy", 32'(busy), 32'd1);
            chk("run.done", 32'(done), 32'd0);
            chk("run.fa_x", 32'(fa_x), 32'(a_v[k]));
            chk("run.fa_y", 32'(fa_y), 32'(b_v[k]));
            chk("run.fa_cin", 32'(fa_cin), 32'(lo >> k));
            chk("run.sum_hold", 32'(sum), 32'(hold_sum));
            chk("run.cout_hold", 32'(cout), 32'(hold_cout));
            if (k + 1 == poke_at) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end
            if (k + 1 == rst_at) begin
                rst = 1'b1;
                tick();
                rst   = 1'b0;
                start = 1'b0;
                hold_sum  = '0;
                hold_cout = 1'b0;
                chk_idle("abort");
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chk_idle("abort_quiet");
                end
                return;
            end
            tick();
        end
        // After edge W: DONE cycle.
        start = 1'b0;
        hold_sum  = total[W-1:0];
        hold_cout = total[W];
        chk("done.done", 32'(done), 32'd1);
        chk("done.busy", 32'(busy), 32'd0);
        chk("done.fa", 32'({fa_x, fa_y, fa_cin}), 32'd0);
        chk("done.sum", 32'(sum), 32'(hold_sum));
        chk("done.cout", 32'(cout), 32'(hold_cout));
        tick();  // edge W+1: back to IDLE
        chk_idle("post");
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        hold_sum  = '0;
        hold_cout = 1'b0;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h55;
        b     = 8'hAA;
        cin   = 1'b1;

        // 1. Reset held with start high: nothing may start.
        tick();
        chk_idle("reset1");
        tick();
        chk_idle("reset2");
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk_idle("reset_rel");

        // 2. Zero operands with carry-in.
        do_op(8'h00, 8'h00, 1'b1, -1, -1);
        chk("s2.sum", 32'(sum), 32'h01);

        // 3. Back-to-back requests.
        do_op(8'hFF, 8'h01, 1'b0, -1, -1);
        chk("s3a.cout", 32'(cout), 32'd1);
        do_op(8'hA5, 8'h5A, 1'b1, -1, -1);
        chk("s3b.sum", 32'(sum), 32'h00);
        do_op(8'hFF, 8'hFF, 1'b1, -1, -1);
        chk("s3c.sum", 32'(sum), 32'hFF);

        // 4. Bit-by-bit adder drive.
        do_op(8'h96, 8'h3C, 1'b0, -1, -1);
        chk("s4.sum", 32'(sum), 32'hD2);

        // 5. Start during RUN is ignored.
        do_op(8'h0F, 8'h01, 1'b0, 3, -1);
        chk("s5.sum", 32'(sum), 32'h10);
        chk("s5.cout", 32'(cout), 32'd0);

        // 6. Reset mid-operation, then a clean restart.
        do_op(8'h80, 8'h80, 1'b0, -1, 4);
        chk("s6.sum_cleared", 32'(sum), 32'h00);
        do_op(8'h80, 8'h80, 1'b0, -1, -1);
        chk("s6.cout", 32'(cout), 32'd1);

        // Randomized operands, with occasional idle gaps between requests.
        for (int n = 0; n < 40; n++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), -1, -1);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                chk_idle("gap");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
